// File: rtl/uarch_pkg.sv
// Shared micro-architecture types for the store queue: entry record,
// pipeline widths and the byte-lane mask helper.
package uarch_pkg;

  localparam int PIPE_WIDTH = 2;
  localparam int TAG_WIDTH  = 6;

  typedef struct packed {
    logic                 valid;
    logic                 addr_ok;
    logic                 committed;
    logic [TAG_WIDTH-1:0] tag;
    logic [31:0]          addr;
    logic [31:0]          data;
    logic [1:0]           size;
  } stq_entry_t;

  // Bytes touched within the aligned word; halves use addr[1] only.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    byte_mask = 4'b0001 << off;
      2'd1:    byte_mask = off[1] ? 4'b1100 : 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/stq_fwd_search.sv
// Age/overlap search over the store queue for a load query.
// STQ_FWD_EN enables data forwarding; otherwise any older store stalls the load.
module stq_fwd_search
  import uarch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  stq_entry_t           entries [DEPTH],
  input  logic [TAG_WIDTH-1:0] rob_head,
  input  logic                 q_valid,
  input  logic [TAG_WIDTH-1:0] q_tag,
  input  logic [31:0]          q_addr,
  input  logic [1:0]           q_size,
  output logic                 hit,
  output logic [31:0]          data,
  output logic                 stall
);

  logic [TAG_WIDTH-1:0] ld_age;
  logic [TAG_WIDTH-1:0] st_age;
  logic                 any_older;

`ifdef STQ_FWD_EN
  logic [3:0]           ld_mask;
  logic [3:0]           st_mask;
  logic [3:0]           best_mask;
  logic [31:0]          best_data;
  logic [1:0]           best_off;
  logic [TAG_WIDTH-1:0] best_age;
  logic                 found;
  logic                 unresolved;
  logic [31:0]          lane_mask;

  always_comb begin
    hit        = 1'b0;
    data       = '0;
    stall      = 1'b0;
    any_older  = 1'b0;
    unresolved = 1'b0;
    found      = 1'b0;
    best_age   = '0;
    best_mask  = '0;
    best_data  = '0;
    best_off   = '0;
    st_mask    = '0;
    lane_mask  = '0;
    ld_age     = q_tag - rob_head;
    ld_mask    = byte_mask(q_size, q_addr[1:0]);
    // Smaller age is older; keep the youngest older store overlapping the load.
    for (int i = 0; i < DEPTH; i++) begin
      st_age = entries[i].tag - rob_head;
      if (entries[i].valid && (st_age < ld_age)) begin
        any_older = 1'b1;
        st_mask   = byte_mask(entries[i].size, entries[i].addr[1:0]);
        if (!entries[i].addr_ok) begin
          unresolved = 1'b1;
        end else if ((entries[i].addr[31:2] == q_addr[31:2]) && ((st_mask & ld_mask) != 4'b0000)
                     && (!found || (st_age > best_age))) begin
          found     = 1'b1;
          best_age  = st_age;
          best_mask = st_mask;
          best_data = entries[i].data;
          best_off  = entries[i].addr[1:0];
        end
      end
    end
    for (int b = 0; b < 4; b++) lane_mask[b*8 +: 8] = {8{best_mask[b]}};
    if (q_valid) begin
      if (unresolved || (found && ((best_mask & ld_mask) != ld_mask))) begin
        stall = 1'b1;
      end else if (found) begin
        hit  = 1'b1;
        data = (best_data << {best_off, 3'b000}) & lane_mask;
      end
    end
  end
`else
  logic unused_bits;

  always_comb begin
    hit         = 1'b0;
    data        = '0;
    any_older   = 1'b0;
    unused_bits = ^{q_addr, q_size};
    ld_age      = q_tag - rob_head;
    st_age      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      st_age      = entries[i].tag - rob_head;
      unused_bits = unused_bits ^ (^entries[i]);
      if (entries[i].valid && (st_age < ld_age)) any_older = 1'b1;
    end
    stall = q_valid & any_older;
  end
`endif

endmodule

// File: rtl/store_queue.sv
// Circular store queue: allocate, resolve, commit, drain to memory, forward to loads.
// Forwarding is built only with STQ_FWD_EN defined (see stq_fwd_search).
module store_queue
  import uarch_pkg::*;
#(
  parameter int STQ_DEPTH      = 8,
  parameter int DISPATCH_WIDTH = PIPE_WIDTH,
  parameter int COMMIT_WIDTH   = PIPE_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     flush,
  input  logic [DISPATCH_WIDTH-1:0]                alloc_valid,
  input  logic [DISPATCH_WIDTH-1:0][TAG_WIDTH-1:0] alloc_tag,
  output logic [DISPATCH_WIDTH-1:0]                alloc_rdy,
  input  logic                                     agu_valid,
  input  logic [TAG_WIDTH-1:0]                     agu_tag,
  input  logic [31:0]                              agu_addr,
  input  logic [31:0]                              agu_data,
  input  logic [1:0]                               agu_size,
  input  logic [COMMIT_WIDTH-1:0]                  commit_valid,
  input  logic [COMMIT_WIDTH-1:0][TAG_WIDTH-1:0]   commit_tag,
  input  logic [TAG_WIDTH-1:0]                     rob_head,
  output logic                                     mem_req_valid,
  output logic [31:0]                              mem_req_addr,
  output logic [31:0]                              mem_req_data,
  output logic [1:0]                               mem_req_size,
  input  logic                                     mem_req_rdy,
  input  logic                                     ld_q_valid,
  input  logic [TAG_WIDTH-1:0]                     ld_q_tag,
  input  logic [31:0]                              ld_q_addr,
  input  logic [1:0]                               ld_q_size,
  output logic                                     ld_fwd_hit,
  output logic [31:0]                              ld_fwd_data,
  output logic                                     ld_fwd_stall,
  output logic [$clog2(STQ_DEPTH+1)-1:0]           stq_count
);

  localparam int IDX_W = $clog2(STQ_DEPTH);
  localparam int CNT_W = $clog2(STQ_DEPTH+1);

  stq_entry_t                entries [STQ_DEPTH];
  stq_entry_t                ent_n   [STQ_DEPTH];
  logic [IDX_W-1:0]          head, tail, head_n, tail_n, slot;
  logic [CNT_W-1:0]          count, count_n;
  logic [DISPATCH_WIDTH-1:0] rdy_int;
  logic                      req_q, pop, head_ready;
  logic [31:0]               req_addr, req_data;
  logic [1:0]                req_size;
  logic                      fwd_hit, fwd_stall;
  logic [31:0]               fwd_data;
  int unsigned               n_acc, n_comm;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= STQ_DEPTH) s = s - STQ_DEPTH;
    return IDX_W'(s);
  endfunction

  always_comb begin
    rdy_int = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) rdy_int[i] = (int'(count) + i) < STQ_DEPTH;
  end

  // mem_req handshake: valid rises only from a registered request and holds its
  // payload until the cycle valid && rdy; the entry pops on that edge and valid drops.
  assign pop        = req_q & mem_req_rdy;
  assign head_ready = entries[head].valid & entries[head].addr_ok & entries[head].committed;

  always_comb begin
    ent_n   = entries;
    n_acc   = 0;
    n_comm  = 0;
    slot    = '0;
    head_n  = pop ? wrap_add(head, 1) : head;
    tail_n  = tail;
    count_n = count;
    for (int i = 0; i < STQ_DEPTH; i++) begin
      if (agu_valid && entries[i].valid && (entries[i].tag == agu_tag)) begin
        ent_n[i].addr_ok = 1'b1;
        ent_n[i].addr    = agu_addr;
        ent_n[i].data    = agu_data;
        ent_n[i].size    = agu_size;
      end
      for (int c = 0; c < COMMIT_WIDTH; c++)
        if (commit_valid[c] && entries[i].valid && (entries[i].tag == commit_tag[c]))
          ent_n[i].committed = 1'b1;
    end
    if (pop) ent_n[head].valid = 1'b0;
    if (flush) begin
      // Committed entries are the oldest ones, so the survivors stay contiguous from head.
      for (int i = 0; i < STQ_DEPTH; i++) begin
        if (!ent_n[i].committed) ent_n[i].valid = 1'b0;
        else if (ent_n[i].valid) n_comm++;
      end
      tail_n  = wrap_add(head_n, n_comm);
      count_n = CNT_W'(n_comm);
    end else begin
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
        if (alloc_valid[l] && rdy_int[l]) begin
          slot            = wrap_add(tail, n_acc);
          ent_n[slot]     = '0;
          ent_n[slot].valid = 1'b1;
          ent_n[slot].tag = alloc_tag[l];
          n_acc++;
        end
      end
      tail_n  = wrap_add(tail, n_acc);
      count_n = count + CNT_W'(n_acc) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      req_q <= 1'b0;
      for (int i = 0; i < STQ_DEPTH; i++) entries[i].valid <= 1'b0;
    end else begin
      head    <= head_n;
      tail    <= tail_n;
      count   <= count_n;
      entries <= ent_n;
      if (pop) begin
        req_q <= 1'b0;
      end else if (!req_q && head_ready) begin
        req_q    <= 1'b1;
        req_addr <= entries[head].addr;
        req_data <= entries[head].data;
        req_size <= entries[head].size;
      end
    end
  end

  stq_fwd_search #(.DEPTH(STQ_DEPTH)) u_fwd (
    .entries  (entries),
    .rob_head (rob_head),
    .q_valid  (ld_q_valid),
    .q_tag    (ld_q_tag),
    .q_addr   (ld_q_addr),
    .q_size   (ld_q_size),
    .hit      (fwd_hit),
    .data     (fwd_data),
    .stall    (fwd_stall)
  );

  assign alloc_rdy     = rst ? '1 : rdy_int;
  assign stq_count     = rst ? '0 : count;
  assign mem_req_valid = req_q & ~rst;
  assign mem_req_addr  = req_addr;
  assign mem_req_data  = req_data;
  assign mem_req_size  = req_size;
  assign ld_fwd_hit    = fwd_hit & ~rst;
  assign ld_fwd_stall  = fwd_stall & ~rst;
  assign ld_fwd_data   = rst ? '0 : fwd_data;

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: drain scoreboard, occupancy, flush and
// load-query checks (forwarding checks when STQ_FWD_EN is defined).
module tb_store_queue;
  import uarch_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = PIPE_WIDTH;
  localparam int CW    = PIPE_WIDTH;
  localparam int TW    = TAG_WIDTH;

  logic                   clk = 1'b0;
  logic                   rst, flush;
  logic [DW-1:0]          alloc_valid, alloc_rdy;
  logic [DW-1:0][TW-1:0]  alloc_tag;
  logic                   agu_valid;
  logic [TW-1:0]          agu_tag;
  logic [31:0]            agu_addr, agu_data;
  logic [1:0]             agu_size;
  logic [CW-1:0]          commit_valid;
  logic [CW-1:0][TW-1:0]  commit_tag;
  logic [TW-1:0]          rob_head;
  logic                   mem_req_valid, mem_req_rdy;
  logic [31:0]            mem_req_addr, mem_req_data;
  logic [1:0]             mem_req_size;
  logic                   ld_q_valid;
  logic [TW-1:0]          ld_q_tag;
  logic [31:0]            ld_q_addr;
  logic [1:0]             ld_q_size;
  logic                   ld_fwd_hit, ld_fwd_stall;
  logic [31:0]            ld_fwd_data;
  logic [$clog2(DEPTH+1)-1:0] stq_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [65:0] exp_q[$];
  logic [65:0] mon_e;

  always #5 clk = ~clk;

  store_queue #(.STQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_rdy(alloc_rdy),
    .agu_valid(agu_valid), .agu_tag(agu_tag), .agu_addr(agu_addr),
    .agu_data(agu_data), .agu_size(agu_size),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .rob_head(rob_head),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_size(mem_req_size), .mem_req_rdy(mem_req_rdy),
    .ld_q_valid(ld_q_valid), .ld_q_tag(ld_q_tag), .ld_q_addr(ld_q_addr),
    .ld_q_size(ld_q_size), .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data),
    .ld_fwd_stall(ld_fwd_stall), .stq_count(stq_count)
  );

  task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input int n, input logic [TW-1:0] t0, input logic [TW-1:0] t1);
    alloc_valid  = DW'((1 << n) - 1);
    alloc_tag[0] = t0;
    alloc_tag[1] = t1;
    tick();
    alloc_valid = '0;
  endtask

  task automatic agu(input logic [TW-1:0] t, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] s);
    agu_valid = 1'b1; agu_tag = t; agu_addr = a; agu_data = d; agu_size = s;
    tick();
    agu_valid = 1'b0;
  endtask

  // Commit in program order; the drain is expected to follow the same order.
  task automatic commit(input logic [TW-1:0] t, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s);
    commit_valid  = 2'b01;
    commit_tag[0] = t;
    exp_q.push_back({s, a, d});
    tick();
    commit_valid = '0;
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!mem_req_valid && k < 20) begin
      tick();
      k++;
    end
    check_eq(tag, mem_req_valid, 1);
  endtask

  task automatic load(input string tag, input logic v, input logic [TW-1:0] t,
                      input logic [31:0] a, input logic [1:0] s,
                      input logic exp_hit, input logic exp_stall);
    ld_q_valid = v; ld_q_tag = t; ld_q_addr = a; ld_q_size = s;
    #1;
    check_eq({tag, "_hit"}, ld_fwd_hit, exp_hit);
    check_eq({tag, "_stall"}, ld_fwd_stall, exp_stall);
  endtask

  always @(negedge clk) begin
    if (!rst && mem_req_valid && mem_req_rdy) begin
      if (exp_q.size() == 0) begin
        check_eq("mem_req_unexpected", mem_req_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("mem_req_size", mem_req_size, mon_e[65:64]);
        check_eq("mem_req_addr", mem_req_addr, mon_e[63:32]);
        check_eq("mem_req_data", mem_req_data, mon_e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_valid = '0; alloc_tag = '0;
    agu_valid = 1'b0; agu_tag = '0; agu_addr = '0; agu_data = '0; agu_size = '0;
    commit_valid = '0; commit_tag = '0; rob_head = '0; mem_req_rdy = 1'b0;
    ld_q_valid = 1'b1; ld_q_tag = 6'd7; ld_q_addr = 32'h100; ld_q_size = 2'd2;

    // Outputs while reset is asserted
    #1;
    check_eq("rst_mem_req_valid", mem_req_valid, 0);
    check_eq("rst_stq_count", stq_count, 0);
    check_eq("rst_alloc_rdy", alloc_rdy, 2'b11);
    check_eq("rst_fwd_hit", ld_fwd_hit, 0);
    check_eq("rst_fwd_stall", ld_fwd_stall, 0);
    tick();
    tick();
    rst = 1'b0;
    ld_q_valid = 1'b0;
    tick();
    check_eq("post_rst_count", stq_count, 0);

    // Dual allocation, then fill to full and pop while full
    alloc(2, 6'd3, 6'd4);
    check_eq("dual_alloc_count", stq_count, 2);
    check_eq("dual_alloc_rdy", alloc_rdy, 2'b11);
    alloc(2, 6'd5, 6'd6);
    alloc(2, 6'd7, 6'd8);
    alloc(2, 6'd9, 6'd10);
    check_eq("full_count", stq_count, 8);
    check_eq("full_rdy", alloc_rdy, 2'b00);
    agu(6'd3, 32'h200, 32'h12345678, 2'd2);
    commit(6'd3, 32'h200, 32'h12345678, 2'd2);
    wait_req("full_req_valid");
    alloc_valid = 2'b01; alloc_tag[0] = 6'd11; mem_req_rdy = 1'b1;
    tick();
    alloc_valid = '0; mem_req_rdy = 1'b0;
    check_eq("pop_no_accept_count", stq_count, 7);
    check_eq("pop_no_accept_rdy", alloc_rdy, 2'b01);
    alloc(1, 6'd11, 6'd0);
    check_eq("wrap_alloc_count", stq_count, 8);
    check_eq("wrap_alloc_rdy", alloc_rdy, 2'b00);
    check_eq("full_drained_q", exp_q.size(), 0);
    do_reset();

    // Request held stable while memory is not ready
    alloc(1, 6'd5, 6'd0);
    agu(6'd5, 32'h100, 32'hAABBCCDD, 2'd2);
    commit(6'd5, 32'h100, 32'hAABBCCDD, 2'd2);
    wait_req("hold_req_valid");
    for (int k = 0; k < 3; k++) begin
      check_eq("hold_valid", mem_req_valid, 1);
      check_eq("hold_addr", mem_req_addr, 32'h100);
      check_eq("hold_data", mem_req_data, 32'hAABBCCDD);
      tick();
    end
    mem_req_rdy = 1'b1;
    tick();
    mem_req_rdy = 1'b0;
    check_eq("hold_after_pop_valid", mem_req_valid, 0);
    check_eq("hold_after_pop_count", stq_count, 0);
    check_eq("hold_drained_q", exp_q.size(), 0);

    // Reset with a request outstanding abandons it
    alloc(1, 6'd1, 6'd0);
    agu(6'd1, 32'h300, 32'hCAFEF00D, 2'd2);
    commit(6'd1, 32'h300, 32'hCAFEF00D, 2'd2);
    wait_req("abandon_req_valid");
    rst = 1'b1;
    #1;
    check_eq("abandon_in_rst_valid", mem_req_valid, 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("abandon_after_valid", mem_req_valid, 0);
    check_eq("abandon_after_count", stq_count, 0);

    // Load queries against stores 5 (word 0x100) and 6 (byte 0x101)
    alloc(2, 6'd5, 6'd6);
    agu(6'd5, 32'h100, 32'h11223344, 2'd2);
    agu(6'd6, 32'h101, 32'h000000EE, 2'd0);
`ifdef STQ_FWD_EN
    load("fwd_byte", 1'b1, 6'd7, 32'h101, 2'd0, 1'b1, 1'b0);
    check_eq("fwd_byte_data", ld_fwd_data[15:8], 8'hEE);
    load("fwd_partial", 1'b1, 6'd7, 32'h100, 2'd2, 1'b0, 1'b1);
    load("fwd_word", 1'b1, 6'd6, 32'h100, 2'd2, 1'b1, 1'b0);
    check_eq("fwd_word_data", ld_fwd_data, 32'h11223344);
    load("fwd_miss", 1'b1, 6'd7, 32'h104, 2'd2, 1'b0, 1'b0);
    load("fwd_idle", 1'b0, 6'd7, 32'h101, 2'd0, 1'b0, 1'b0);
    ld_q_valid = 1'b0;
    alloc(1, 6'd8, 6'd0);
    load("fwd_unresolved", 1'b1, 6'd9, 32'h101, 2'd0, 1'b0, 1'b1);
`else
    load("nofwd_older", 1'b1, 6'd7, 32'h101, 2'd0, 1'b0, 1'b1);
    check_eq("nofwd_data", ld_fwd_data, 32'h0);
    load("nofwd_oldest", 1'b1, 6'd5, 32'h100, 2'd2, 1'b0, 1'b0);
    load("nofwd_idle", 1'b0, 6'd7, 32'h101, 2'd0, 1'b0, 1'b0);
`endif
    ld_q_valid = 1'b0;
    do_reset();

    // Flush keeps only the committed store; allocation in the flush cycle is dropped
    alloc(2, 6'd2, 6'd3);
    alloc(1, 6'd4, 6'd0);
    agu(6'd2, 32'h400, 32'h00000022, 2'd0);
    agu(6'd3, 32'h404, 32'h00000033, 2'd2);
    agu(6'd4, 32'h408, 32'h00000044, 2'd2);
    commit(6'd2, 32'h400, 32'h00000022, 2'd0);
    flush = 1'b1; alloc_valid = 2'b01; alloc_tag[0] = 6'd9;
    tick();
    flush = 1'b0; alloc_valid = '0;
    check_eq("flush_count", stq_count, 1);
    mem_req_rdy = 1'b1;
    for (int k = 0; k < 20 && stq_count != 0; k++) tick();
    check_eq("flush_drain_count", stq_count, 0);
    tick();
    tick();
    mem_req_rdy = 1'b0;
    check_eq("flush_after_valid", mem_req_valid, 0);
    check_eq("flush_drained_q", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
